// File: rtl/cpu_seq_pkg.sv
// Shared types and helpers for the instruction-stage sequencer.
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } seq_state_e;

    // Widest stage vector the onehot helper can produce.
    localparam int MAX_STAGES = 64;

    // Width of a stage index for n stages, never less than one bit.
    function automatic int stage_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // One-hot vector with bit idx set; callers keep the low STAGES bits.
    function automatic logic [MAX_STAGES-1:0] onehot(input int unsigned idx);
        logic [MAX_STAGES-1:0] one;
        one = {{(MAX_STAGES-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Control and status bundle between a CPU core controller and the sequencer.
interface stage_sequencer_if
    import cpu_seq_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int CNT_W  = 32
);
    localparam int STAGE_W = stage_width(STAGES);

    logic               run;
    logic               step;
    logic               stall;
    logic [STAGES-1:0]  clk;
    logic [STAGE_W-1:0] stage_idx;
    logic               halted;
    logic               instr_done;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        output run, step, stall,
        input  clk, stage_idx, halted, instr_done, instr_count
    );

    modport slave (
        input  run, step, stall,
        output clk, stage_idx, halted, instr_done, instr_count
    );

endinterface

// File: rtl/stage_sequencer_phase_timer.sv
// Loadable down-counter timing one ACTIVE or GAP interval; hold freezes it.
module phase_timer #(
    parameter int W = 1
) (
    input  logic         hw_clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         hold,
    output logic         expire
);
    logic [W-1:0] cnt;

    // Load wins over hold; the count rests at zero once expired.
    always_ff @(posedge hw_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!hold && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/stage_sequencer.sv
// Generates STAGES non-overlapping one-hot stage enables with run/step/stall
// control and a retired-instruction counter. All outputs are registered.
module stage_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int STAGES        = 4,
    parameter int ACTIVE_CYCLES = 1,
    parameter int GAP_CYCLES    = 1,
    parameter int CNT_W         = 32
) (
    input  logic             hw_clk,
    input  logic             reset_n,
    stage_sequencer_if.slave bus
);
    localparam int STAGE_W = stage_width(STAGES);
    localparam int MAXC    = (ACTIVE_CYCLES > GAP_CYCLES) ? ACTIVE_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = ($clog2(MAXC + 1) > 1) ? $clog2(MAXC + 1) : 1;

    // Timer loads are interval-1 because the expiry cycle itself counts.
    localparam logic [TMR_W-1:0]   ACT_LOAD = TMR_W'(ACTIVE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   GAP_LOAD = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [STAGE_W-1:0] LAST_IDX = STAGE_W'(STAGES - 1);

    seq_state_e              state_q, state_d;
    logic [STAGE_W-1:0]      idx_q, idx_d;
    logic [STAGES-1:0]       clk_q, clk_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    halted_q;
    logic                    done_q, done_d;
    logic                    ss_q, ss_d;
    logic                    adv;
    logic                    tmr_load;
    logic [TMR_W-1:0]        tmr_val;
    logic                    tmr_expire;
    logic [MAX_STAGES-1:0]   oh_wide;

    phase_timer #(.W(TMR_W)) u_timer (
        .hw_clk   (hw_clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .hold     (bus.stall),
        .expire   (tmr_expire)
    );

    // State, stage index and all registered outputs.
    always_ff @(posedge hw_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= HALTED;
            idx_q    <= '0;
            clk_q    <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b1;
            done_q   <= 1'b0;
            ss_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            clk_q    <= clk_d;
            cnt_q    <= cnt_d;
            halted_q <= (state_d == HALTED);
            done_q   <= done_d;
            ss_q     <= ss_d;
        end
    end

    // Next-state logic; enables derive from the next state and index only.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        ss_d     = ss_q;
        adv      = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = ACT_LOAD;

        case (state_q)
            HALTED: begin
                if (bus.run || bus.step) begin
                    state_d  = ACTIVE;
                    idx_d    = '0;
                    ss_d     = !bus.run;
                    tmr_load = 1'b1;
                    tmr_val  = ACT_LOAD;
                end
            end
            ACTIVE: begin
                if (!bus.stall && tmr_expire) begin
                    if (GAP_CYCLES > 0) begin
                        state_d  = GAP;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            GAP: begin
                if (!bus.stall && tmr_expire) begin
                    adv = 1'b1;
                end
            end
            default: state_d = HALTED;
        endcase

        if (adv) begin
            if (idx_q != LAST_IDX) begin
                idx_d    = idx_q + STAGE_W'(1);
                state_d  = ACTIVE;
                tmr_load = 1'b1;
                tmr_val  = ACT_LOAD;
            end else begin
                done_d = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (bus.run && !ss_q) begin
                    idx_d    = '0;
                    state_d  = ACTIVE;
                    tmr_load = 1'b1;
                    tmr_val  = ACT_LOAD;
                end else begin
                    state_d = HALTED;
                end
            end
        end

        oh_wide = onehot(int'(idx_d));
        clk_d   = (state_d == ACTIVE) ? oh_wide[STAGES-1:0] : '0;
    end

    assign bus.clk         = clk_q;
    assign bus.stage_idx   = idx_q;
    assign bus.halted      = halted_q;
    assign bus.instr_done  = done_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised instruction-stage sequencer. It generates STAGES non-overlapping, one-hot stage enables from a single free-running hw_clk.
- Successor to the fixed 4-phase splitter. Adds configurable stage count, active width and inter-stage gap, plus run/halt, single-step, stall and an instruction counter.
- Drives the fetch / read / read-write / write stage logic of the CPU core.

Parameters:
- STAGES, 4, number of stages per instruction (min 2).
- ACTIVE_CYCLES, 1, hw_clk cycles each stage enable is high (min 1).
- GAP_CYCLES, 1, hw_clk cycles with all enables low after each stage (min 0).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- hw_clk, input, 1, sole clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- run, input, 1, level: continuous execution while high.
- step, input, 1, one-cycle pulse: execute exactly one instruction when halted.
- stall, input, 1, level: freeze sequencing in the current cycle state.
- clk, output, STAGES, registered one-hot stage enables; bit i is stage i.
- stage_idx, output, $clog2(STAGES), index of the current or most recent stage.
- halted, output, 1, high in HALTED state.
- instr_done, output, 1, one-cycle pulse when an instruction's last stage and gap complete.
- instr_count, output, CNT_W, retired instructions; wraps modulo 2^CNT_W.

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset (asynchronous, any time, including mid-instruction):
  - state=HALTED, clk=0, stage_idx=0, halted=1, instr_done=0, instr_count=0.
  - Internal timer and single-shot flag cleared.
- States: HALTED, ACTIVE, GAP.
- HALTED:
  - clk=0.
  - Edge with run=1: go to ACTIVE, stage_idx=0, clk=1<<0, single-shot=0.
  - Else edge with step=1: same transition, single-shot=1.
  - run and step both high: run wins, single-shot=0.
  - stall is ignored in HALTED.
- ACTIVE:
  - clk=1<<stage_idx for exactly ACTIVE_CYCLES cycles.
  - After that, go to GAP if GAP_CYCLES>0, else advance directly (see Advance).
- GAP:
  - clk=0 for GAP_CYCLES cycles, then Advance.
- Advance:
  - If stage_idx<STAGES-1: stage_idx+1, go to ACTIVE.
  - If stage_idx=STAGES-1, instruction end:
    - instr_done=1 for one cycle; instr_count+1, wrapping.
    - If run=1 and single-shot=0: stage_idx=0, ACTIVE on the same edge, no bubble.
    - Else go to HALTED; stage_idx keeps STAGES-1.
- Instruction period is STAGES*(ACTIVE_CYCLES+GAP_CYCLES) cycles.
- First enable is visible after the first edge that samples run or step high.
- run deassertion mid-instruction takes effect only at the instruction boundary; the current instruction always completes.
- run asserted during a single-shot instruction does not extend it; the core halts, then restarts on the next edge if run is still high.
- step pulses outside HALTED are ignored; they are not queued.
- stall=1 in ACTIVE or GAP:
  - Timer, state, clk and stage_idx hold.
  - No Advance and no instr_done on that edge; a pending boundary is deferred until stall drops.
  - The held enable stays high, which extends its width.
- clk is never multi-hot; at most one bit is high in any cycle.

Decomposition:
- Shared package cpu_seq_pkg holds:
  - enum seq_state_e {HALTED, ACTIVE, GAP}.
  - Constant STAGE_W = $clog2(STAGES), with a floor of 1.
  - Function onehot(idx).
- One sub-module, phase_timer:
  - Loadable down-counter with a hold input (driven by stall).
  - Asserts expire when the count reaches 0.
  - Width $clog2(max(ACTIVE_CYCLES,GAP_CYCLES)+1).
  - Reused for both ACTIVE and GAP intervals.

Test Plan:
- Defaults, run=1 after reset:
  - clk sequence 0001,0000,0010,0000,0100,0000,1000,0000, repeating.
  - instr_done pulses every 8 cycles; instr_count reaches 3 after 24 cycles.
- Halted, one step pulse:
  - Exactly one 8-cycle instruction runs, then halted=1 and instr_count=1.
  - A second step pulse issued mid-instruction has no effect.
- STAGES=6, ACTIVE_CYCLES=2, GAP_CYCLES=0, run=1:
  - Each bit high 2 cycles back-to-back; period 12.
  - clk stays one-hot on every cycle.
- run=1, stall high 5 cycles while clk=0100:
  - clk holds 0100 for 5 extra cycles, then continues.
  - instr_done is delayed by 5 cycles.
- run dropped during stage 1, then reset_n pulsed low during stage 2 of a re-run:
  - First instruction completes, then halts.
  - On the reset: immediate clk=0, instr_count=0, halted=1.
- CNT_W=4, run for 16 instructions:
  - instr_count wraps 15->0 with instr_done still pulsing.
